// File: rtl/ddr_rx_sequencer_if.sv
// ddr_rx_sequencer_if
// Groups the engine, SCL-strobe, RX and read-FIFO signals of the HDR-DDR
// read-path sequencer.
//   master : the environment (engine FSM, scl_generation, RX, FIFO); drives
//            the i_* signals and observes the o_* signals.
//   slave  : the sequencer itself; samples i_* and drives o_*.
interface ddr_rx_sequencer_if;
   logic       i_engine_rd_start;
   logic       i_engine_rd_abort;
   logic       i_sclgen_scl_pos_edge;
   logic       i_sclgen_scl_neg_edge;
   logic       i_rx_mode_done;
   logic       i_rx_pre;
   logic       i_rx_error;
   logic [7:0] i_rx_data;
   logic       i_fifo_full;
   logic       o_rx_en;
   logic [3:0] o_rx_mode;
   logic [4:0] o_bitcnt;
   logic       o_fifo_wr_en;
   logic [7:0] o_fifo_wr_data;
   logic [7:0] o_word_count;
   logic       o_done;
   logic       o_error;
   logic [2:0] o_error_code;

   modport master (
      output i_engine_rd_start, i_engine_rd_abort, i_sclgen_scl_pos_edge,
             i_sclgen_scl_neg_edge, i_rx_mode_done, i_rx_pre, i_rx_error,
             i_rx_data, i_fifo_full,
      input  o_rx_en, o_rx_mode, o_bitcnt, o_fifo_wr_en, o_fifo_wr_data,
             o_word_count, o_done, o_error, o_error_code
   );

   modport slave (
      input  i_engine_rd_start, i_engine_rd_abort, i_sclgen_scl_pos_edge,
             i_sclgen_scl_neg_edge, i_rx_mode_done, i_rx_pre, i_rx_error,
             i_rx_data, i_fifo_full,
      output o_rx_en, o_rx_mode, o_bitcnt, o_fifo_wr_en, o_fifo_wr_data,
             o_word_count, o_done, o_error, o_error_code
   );
endinterface

// File: rtl/ddr_rx_sequencer.sv
// ddr_rx_sequencer
// HDR-DDR read-path sequencer: steps the RX deserializer through preamble,
// data bytes, parity, CRC token and CRC value; pushes received bytes into the
// read FIFO and reports completion or error to the engine FSM.
// Ports:
//   i_sys_clk  : system clock
//   i_sys_rst  : synchronous active-high reset
//   bus        : ddr_rx_sequencer_if.slave (engine, SCL strobes, RX, FIFO)
// Parameters:
//   MAX_WORDS  : data words accepted per transfer (1..255)
//   WD_CYCLES  : watchdog limit in clock cycles
// Optional build macro: DDR_RX_SEQ_WATCHDOG_EN compiles in the watchdog
// (error code 4). Without it the sequencer waits indefinitely.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for i_engine_rd_start
// S_PRE     | receiving 2-bit preamble (data vs CRC word)
// S_BYTE1   | receiving first data byte
// S_BYTE2   | receiving second data byte
// S_PAR     | receiving parity bits of the data word
// S_TOK     | receiving CRC token
// S_CRC     | receiving CRC value
// S_DONE    | one-cycle good completion, o_done pulses
// S_ERR     | one-cycle error exit, o_error pulses
module ddr_rx_sequencer #(
   parameter int MAX_WORDS = 16,
   parameter int WD_CYCLES = 1024
) (
   input logic              i_sys_clk,
   input logic              i_sys_rst,
   ddr_rx_sequencer_if.slave bus
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_PRE   = 4'd1;
   localparam logic [3:0] S_BYTE1 = 4'd2;
   localparam logic [3:0] S_BYTE2 = 4'd3;
   localparam logic [3:0] S_PAR   = 4'd4;
   localparam logic [3:0] S_TOK   = 4'd5;
   localparam logic [3:0] S_CRC   = 4'd6;
   localparam logic [3:0] S_DONE  = 4'd7;
   localparam logic [3:0] S_ERR   = 4'd8;

   logic [3:0] state, nxt_state;
   logic [2:0] nxt_code;
   logic       wr_fire, inc_word, state_chg, active, wd_expire;
   logic       ld_en;
   logic [3:0] ld_mode;
   logic [4:0] ld_cnt;

   assign active    = (state >= S_PRE) && (state <= S_CRC);
   assign state_chg = (nxt_state != state);

`ifdef DDR_RX_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(WD_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   // Expires on the cycle the count would reach WD_CYCLES, so the ERROR
   // state lands exactly WD_CYCLES cycles after the last state entry.
   assign wd_expire = active && (wd_cnt == WD_W'(WD_CYCLES - 1));

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst || state_chg || bus.i_rx_mode_done || !active)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end
`else
   // Watchdog compiled out: never fires for any legal WD_CYCLES.
   assign wd_expire = (WD_CYCLES < 0);
`endif

   always_comb begin
      nxt_state = state;
      nxt_code  = 3'd0;
      wr_fire   = 1'b0;
      inc_word  = 1'b0;
      case (state)
         S_IDLE: if (bus.i_engine_rd_start) nxt_state = S_PRE;
         S_DONE, S_ERR: nxt_state = S_IDLE;
         S_PRE, S_BYTE1, S_BYTE2, S_PAR, S_TOK, S_CRC: begin
            if (bus.i_engine_rd_abort) begin
               nxt_state = S_ERR;
               nxt_code  = 3'd5;
            end else if (bus.i_rx_mode_done) begin
               case (state)
                  S_PRE: begin
                     if (!bus.i_rx_pre)
                        nxt_state = S_TOK;
                     else if (bus.o_word_count == 8'(MAX_WORDS)) begin
                        nxt_state = S_ERR;
                        nxt_code  = 3'd3;
                     end else
                        nxt_state = S_BYTE1;
                  end
                  S_BYTE1, S_BYTE2: begin
                     if (bus.i_fifo_full) begin
                        nxt_state = S_ERR;
                        nxt_code  = 3'd2;
                     end else begin
                        wr_fire   = 1'b1;
                        nxt_state = (state == S_BYTE1) ? S_BYTE2 : S_PAR;
                     end
                  end
                  S_PAR: begin
                     if (bus.i_rx_error) begin
                        nxt_state = S_ERR;
                        nxt_code  = 3'd1;
                     end else begin
                        inc_word  = 1'b1;
                        nxt_state = S_PRE;
                     end
                  end
                  S_TOK, S_CRC: begin
                     if (bus.i_rx_error) begin
                        nxt_state = S_ERR;
                        nxt_code  = 3'd1;
                     end else
                        nxt_state = (state == S_TOK) ? S_CRC : S_DONE;
                  end
                  default: nxt_state = S_IDLE;
               endcase
            end else if (wd_expire) begin
               nxt_state = S_ERR;
               nxt_code  = 3'd4;
            end
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   // RX enable, mode and length-1 loaded on entry to each state.
   always_comb begin
      ld_en   = 1'b0;
      ld_mode = 4'b0000;
      ld_cnt  = 5'd0;
      case (nxt_state)
         S_PRE:            begin ld_en = 1'b1; ld_mode = 4'b0000; ld_cnt = 5'd1; end
         S_BYTE1, S_BYTE2: begin ld_en = 1'b1; ld_mode = 4'b0011; ld_cnt = 5'd7; end
         S_PAR:            begin ld_en = 1'b1; ld_mode = 4'b0110; ld_cnt = 5'd1; end
         S_TOK:            begin ld_en = 1'b1; ld_mode = 4'b0111; ld_cnt = 5'd3; end
         S_CRC:            begin ld_en = 1'b1; ld_mode = 4'b1000; ld_cnt = 5'd4; end
         default:          begin ld_en = 1'b0; ld_mode = 4'b0000; ld_cnt = 5'd0; end
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state              <= S_IDLE;
         bus.o_rx_en        <= 1'b0;
         bus.o_rx_mode      <= 4'b0000;
         bus.o_bitcnt       <= 5'd0;
         bus.o_fifo_wr_en   <= 1'b0;
         bus.o_fifo_wr_data <= 8'd0;
         bus.o_word_count   <= 8'd0;
         bus.o_done         <= 1'b0;
         bus.o_error        <= 1'b0;
         bus.o_error_code   <= 3'd0;
      end else begin
         state            <= nxt_state;
         bus.o_fifo_wr_en <= wr_fire;
         if (wr_fire)
            bus.o_fifo_wr_data <= bus.i_rx_data;
         bus.o_done  <= (nxt_state == S_DONE) && state_chg;
         bus.o_error <= (nxt_state == S_ERR) && state_chg;

         if (state == S_IDLE && bus.i_engine_rd_start) begin
            bus.o_word_count <= 8'd0;
            bus.o_error_code <= 3'd0;
         end else begin
            if (inc_word)
               bus.o_word_count <= bus.o_word_count + 8'd1;
            if (nxt_state == S_ERR && state_chg)
               bus.o_error_code <= nxt_code;
         end

         // A strobe coincident with a state change is dropped: reload wins.
         if (state_chg) begin
            bus.o_rx_en   <= ld_en;
            bus.o_rx_mode <= ld_mode;
            bus.o_bitcnt  <= ld_cnt;
         end else if (bus.o_rx_en && (bus.i_sclgen_scl_pos_edge || bus.i_sclgen_scl_neg_edge)
                      && bus.o_bitcnt != 5'd0) begin
            bus.o_bitcnt <= bus.o_bitcnt - 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_ddr_rx_sequencer.sv
module tb_ddr_rx_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ddr_rx_sequencer_if bus();

   ddr_rx_sequencer #(.MAX_WORDS(3), .WD_CYCLES(64)) dut (
      .i_sys_clk (clk),
      .i_sys_rst (rst),
      .bus       (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_wr = 0;
   int n_done_p = 0;
   int n_err_p = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // FIFO scoreboard and pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.o_done)  n_done_p++;
      if (bus.o_error) n_err_p++;
      if (bus.o_fifo_wr_en) begin
         n_wr++;
         if (exp_q.size() == 0)
            chk("fifo_extra_wr", {24'd0, bus.o_fifo_wr_data}, 32'hFFFF_FFFF);
         else
            chk("fifo_wr_data", {24'd0, bus.o_fifo_wr_data}, {24'd0, exp_q.pop_front()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic pos, input logic neg);
      bus.i_sclgen_scl_pos_edge = pos;
      bus.i_sclgen_scl_neg_edge = neg;
      tick();
      bus.i_sclgen_scl_pos_edge = 1'b0;
      bus.i_sclgen_scl_neg_edge = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) strobe(i[0] == 1'b0, i[0] == 1'b1);
   endtask

   task automatic mode_done(input logic pre, input logic err, input logic full,
                            input logic [7:0] data, input logic expect_wr);
      bus.i_rx_pre       = pre;
      bus.i_rx_error     = err;
      bus.i_fifo_full    = full;
      bus.i_rx_data      = data;
      bus.i_rx_mode_done = 1'b1;
      if (expect_wr) exp_q.push_back(data);
      tick();
      bus.i_rx_mode_done = 1'b0;
      bus.i_rx_error     = 1'b0;
      bus.i_fifo_full    = 1'b0;
   endtask

   task automatic start();
      bus.i_engine_rd_start = 1'b1;
      tick();
      bus.i_engine_rd_start = 1'b0;
   endtask

   task automatic data_word(input logic [7:0] a, input logic [7:0] b);
      mode_done(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      gap(2);
      mode_done(1'b0, 1'b0, 1'b0, a, 1'b1);
      gap(3);
      mode_done(1'b0, 1'b0, 1'b0, b, 1'b1);
      gap(1);
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic crc_word();
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      gap(2);
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      gap(2);
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   int wr0, dp0, ep0, k;

   initial begin
      bus.i_engine_rd_start = 0; bus.i_engine_rd_abort = 0;
      bus.i_sclgen_scl_pos_edge = 0; bus.i_sclgen_scl_neg_edge = 0;
      bus.i_rx_mode_done = 0; bus.i_rx_pre = 0; bus.i_rx_error = 0;
      bus.i_rx_data = 0; bus.i_fifo_full = 0;
      repeat (3) tick();
      chk("rst_rx_en", {31'd0, bus.o_rx_en}, 0);
      chk("rst_mode", {28'd0, bus.o_rx_mode}, 0);
      chk("rst_bitcnt", {27'd0, bus.o_bitcnt}, 0);
      chk("rst_wr_en", {31'd0, bus.o_fifo_wr_en}, 0);
      chk("rst_wr_data", {24'd0, bus.o_fifo_wr_data}, 0);
      chk("rst_wcount", {24'd0, bus.o_word_count}, 0);
      chk("rst_done_err", {30'd0, bus.o_done, bus.o_error}, 0);
      chk("rst_code", {29'd0, bus.o_error_code}, 0);
      rst = 1'b0;
      tick();

      // single data word + CRC word, with bitcnt behaviour
      wr0 = n_wr; dp0 = n_done_p;
      start();
      chk("t1_pre_en", {31'd0, bus.o_rx_en}, 1);
      chk("t1_pre_cnt", {27'd0, bus.o_bitcnt}, 1);
      chk("t1_pre_mode", {28'd0, bus.o_rx_mode}, 0);
      strobe(1'b1, 1'b0);
      chk("t1_dec", {27'd0, bus.o_bitcnt}, 0);
      strobe(1'b0, 1'b1);
      chk("t1_sat", {27'd0, bus.o_bitcnt}, 0);
      mode_done(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t1_b1_mode", {28'd0, bus.o_rx_mode}, 4'b0011);
      chk("t1_b1_cnt", {27'd0, bus.o_bitcnt}, 7);
      gap(3);
      chk("t1_b1_cnt3", {27'd0, bus.o_bitcnt}, 4);
      bus.i_sclgen_scl_pos_edge = 1'b1;
      mode_done(1'b0, 1'b0, 1'b0, 8'hAD, 1'b1);
      bus.i_sclgen_scl_pos_edge = 1'b0;
      chk("t1_b2_reload", {27'd0, bus.o_bitcnt}, 7);
      mode_done(1'b0, 1'b0, 1'b0, 8'hCA, 1'b1);
      chk("t1_par_mode", {28'd0, bus.o_rx_mode}, 4'b0110);
      chk("t1_par_cnt", {27'd0, bus.o_bitcnt}, 1);
      chk("t1_wc_before", {24'd0, bus.o_word_count}, 0);
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t1_wc", {24'd0, bus.o_word_count}, 1);
      chk("t1_pre2_cnt", {27'd0, bus.o_bitcnt}, 1);
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t1_tok_mode", {28'd0, bus.o_rx_mode}, 4'b0111);
      chk("t1_tok_cnt", {27'd0, bus.o_bitcnt}, 3);
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t1_crc_mode", {28'd0, bus.o_rx_mode}, 4'b1000);
      chk("t1_crc_cnt", {27'd0, bus.o_bitcnt}, 4);
      mode_done(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t1_done", {31'd0, bus.o_done}, 1);
      chk("t1_done_rxen", {31'd0, bus.o_rx_en}, 0);
      tick();
      chk("t1_done_1cyc", {31'd0, bus.o_done}, 0);
      chk("t1_done_cnt", n_done_p - dp0, 1);
      chk("t1_writes", n_wr - wr0, 2);
      chk("t1_code", {29'd0, bus.o_error_code}, 0);
      chk("t1_q_empty", exp_q.size(), 0);

      // three data words (== MAX_WORDS) then CRC; start mid-transfer ignored
      wr0 = n_wr; dp0 = n_done_p;
      start();
      chk("t2_wc_clr", {24'd0, bus.o_word_count}, 0);
      data_word(8'h11, 8'h22);
      start();
      chk("t2_start_ign", {24'd0, bus.o_word_count}, 1);
      data_word(8'h33, 8'h44);
      data_word(8'h55, 8'h66);
      crc_word();
      chk("t2_done", {31'd0, bus.o_done}, 1);
      tick();
      chk("t2_wc", {24'd0, bus.o_word_count}, 3);
      chk("t2_writes", n_wr - wr0, 6);
      chk("t2_done_cnt", n_done_p - dp0, 1);

      // RX error at parity
      ep0 = n_err_p;
      start();
      mode_done(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      mode_done(1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
      mode_done(1'b0, 1'b0, 1'b0, 8'h02, 1'b1);
      mode_done(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("t3_err", {31'd0, bus.o_error}, 1);
      chk("t3_code", {29'd0, bus.o_error_code}, 1);
      chk("t3_wc", {24'd0, bus.o_word_count}, 0);
      tick();
      chk("t3_idle_en", {31'd0, bus.o_rx_en}, 0);
      chk("t3_err_1cyc", {31'd0, bus.o_error}, 0);
      chk("t3_err_cnt", n_err_p - ep0, 1);

      // FIFO full at BYTE2
      wr0 = n_wr;
      start();
      chk("t4_code_clr", {29'd0, bus.o_error_code}, 0);
      mode_done(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      mode_done(1'b0, 1'b0, 1'b0, 8'hB1, 1'b1);
      mode_done(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0);
      chk("t4_err", {31'd0, bus.o_error}, 1);
      tick();
      chk("t4_code", {29'd0, bus.o_error_code}, 2);
      chk("t4_writes", n_wr - wr0, 1);

      // word overflow: data preamble after MAX_WORDS words
      wr0 = n_wr;
      start();
      data_word(8'hC1, 8'hC2);
      data_word(8'hC3, 8'hC4);
      data_word(8'hC5, 8'hC6);
      mode_done(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t5_err", {31'd0, bus.o_error}, 1);
      chk("t5_code", {29'd0, bus.o_error_code}, 3);
      mode_done(1'b0, 1'b0, 1'b0, 8'hEE, 1'b0);
      tick();
      chk("t5_writes", n_wr - wr0, 6);

      // abort together with BYTE1 done
      wr0 = n_wr;
      start();
      mode_done(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      bus.i_engine_rd_abort = 1'b1;
      mode_done(1'b0, 1'b1, 1'b1, 8'hDD, 1'b0);
      bus.i_engine_rd_abort = 1'b0;
      chk("t6_err", {31'd0, bus.o_error}, 1);
      chk("t6_code", {29'd0, bus.o_error_code}, 5);
      tick();
      chk("t6_writes", n_wr - wr0, 0);

      // abort in IDLE ignored
      ep0 = n_err_p;
      bus.i_engine_rd_abort = 1'b1;
      repeat (3) tick();
      bus.i_engine_rd_abort = 1'b0;
      tick();
      chk("t7_idle_abort", n_err_p - ep0, 0);
      chk("t7_idle_en", {31'd0, bus.o_rx_en}, 0);

      // reset mid-transfer
      wr0 = n_wr; dp0 = n_done_p; ep0 = n_err_p;
      start();
      mode_done(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      mode_done(1'b0, 1'b0, 1'b0, 8'h77, 1'b0);
      rst = 1'b0;
      chk("t8_rst_en", {31'd0, bus.o_rx_en}, 0);
      tick();
      chk("t8_rst_wr", n_wr - wr0, 0);
      chk("t8_rst_pulses", (n_done_p - dp0) + (n_err_p - ep0), 0);

      // watchdog
      ep0 = n_err_p;
      start();
`ifdef DDR_RX_SEQ_WATCHDOG_EN
      k = 0;
      while (bus.o_error !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      chk("t9_wd_cycles", k, 64);
      chk("t9_wd_code", {29'd0, bus.o_error_code}, 4);
      tick();
`else
      repeat (150) tick();
      chk("t9_no_wd_en", {31'd0, bus.o_rx_en}, 1);
      chk("t9_no_wd_err", n_err_p - ep0, 0);
      bus.i_engine_rd_abort = 1'b1;
      tick();
      bus.i_engine_rd_abort = 1'b0;
      chk("t9_abort_code", {29'd0, bus.o_error_code}, 5);
      tick();
`endif
      chk("final_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ddr_rx_sequencer.md
# ddr_rx_sequencer

HDR-DDR read-path sequencer that drives the `RX` deserializer through a complete target-to-controller read transfer. It selects the RX mode, loads the bit counter, and moves received bytes into the read FIFO. It also checks word framing and reports transfer completion or error to the DDR CCC/engine FSM. It sits between the engine FSM, the `RX` block and the `scl_generation` edge strobes.

## Interface
Parameters:
- `MAX_WORDS`, 16: maximum data words accepted per read transfer (1..255).
- `WD_CYCLES`, 1024: watchdog limit in `i_sys_clk` cycles (used only with the watchdog compiled in).

Ports:
- `i_sys_clk` in 1: system clock. Synchronous design, single clock.
- `i_sys_rst` in 1: synchronous, active-high reset.
- `i_engine_rd_start` in 1: one-cycle pulse that starts a read transfer.
- `i_engine_rd_abort` in 1: abort the transfer; level-sensitive, sampled every cycle.
- `i_sclgen_scl_pos_edge` in 1: SCL rising-edge strobe.
- `i_sclgen_scl_neg_edge` in 1: SCL falling-edge strobe.
- `i_rx_mode_done` in 1: RX has finished the current mode.
- `i_rx_pre` in 1: value of the second preamble bit (1 = data word, 0 = CRC word).
- `i_rx_error` in 1: RX reported a parity, token or CRC mismatch.
- `i_rx_data` in 8: deserialized byte.
- `i_fifo_full` in 1: read FIFO is full.
- `o_rx_en` out 1: enable to RX.
- `o_rx_mode` out 4: RX mode select.
- `o_bitcnt` out 5: remaining-bit count to RX.
- `o_fifo_wr_en` out 1: one-cycle FIFO write strobe.
- `o_fifo_wr_data` out 8: byte written to the FIFO.
- `o_word_count` out 8: data words completed in this transfer.
- `o_done` out 1: one-cycle pulse on good completion.
- `o_error` out 1: one-cycle pulse on error.
- `o_error_code` out 3: error cause; held until the next start.

## Operation
- States: IDLE, PREAMBLE, BYTE1, BYTE2, PARITY, CRC_TOKEN, CRC_VALUE, DONE, ERROR.
- RX mode encoding per state:
  - PREAMBLE 4'b0000, BYTE1/BYTE2 4'b0011, PARITY 4'b0110, CRC_TOKEN 4'b0111, CRC_VALUE 4'b1000.
  - IDLE/DONE/ERROR drive 4'b0000 with `o_rx_en`=0.
- Bit lengths loaded into `o_bitcnt` on state entry (length−1): PREAMBLE 1, BYTE 7, PARITY 1, CRC_TOKEN 3, CRC_VALUE 4.
- `o_bitcnt` decrements on either SCL strobe while `o_rx_en`=1. It saturates at 0.
- IDLE → PREAMBLE on `i_engine_rd_start`. The start also clears `o_word_count` and `o_error_code`.
- PREAMBLE, on `i_rx_mode_done`:
  - `i_rx_pre`=1 → BYTE1, unless `o_word_count`==`MAX_WORDS`, which goes to ERROR with code 3.
  - `i_rx_pre`=0 → CRC_TOKEN.
- BYTE1 → BYTE2, and BYTE2 → PARITY, on `i_rx_mode_done`. Each transition writes `i_rx_data` to the FIFO. If `i_fifo_full`=1 at that moment, no write occurs and the next state is ERROR with code 2.
- PARITY, on done: with `i_rx_error`=1 → ERROR code 1. Otherwise `o_word_count`+1 and → PREAMBLE.
- CRC_TOKEN, on done: error → ERROR code 1, else → CRC_VALUE.
- CRC_VALUE, on done: error → ERROR code 1, else → DONE.
- DONE → IDLE after one cycle, pulsing `o_done`.
- ERROR → IDLE after one cycle, pulsing `o_error`.
- Error codes: 0 none, 1 RX error, 2 FIFO overrun, 3 word overflow, 4 watchdog, 5 abort.
- Abort:
  - In any non-IDLE state, `i_engine_rd_abort` forces ERROR with code 5 on the next cycle.
  - Abort has priority over `i_rx_mode_done` and over all errors in the same cycle.
  - Abort in IDLE is ignored.
- `i_engine_rd_start` outside IDLE is ignored.

## Timing
- All outputs are registered. Reset values: `o_rx_en`=0, `o_rx_mode`=0, `o_bitcnt`=0, `o_fifo_wr_en`=0, `o_fifo_wr_data`=0, `o_word_count`=0, `o_done`=0, `o_error`=0, `o_error_code`=0.
- Start pulse at cycle N → PREAMBLE, `o_rx_en`=1 and `o_bitcnt`=1 at cycle N+1.
- `i_rx_mode_done` at cycle N → new state, mode and bitcnt at N+1.
- In the BYTE states, `i_rx_mode_done` at N → `o_fifo_wr_en`=1 and `o_fifo_wr_data`=`i_rx_data`(N) at N+1.
- `o_word_count` updates at N+1 after a good PARITY done.
- `o_done` and `o_error` are high for exactly one cycle. The DONE or ERROR state is the cycle after the final done; IDLE follows.
- An SCL strobe coincident with a state change is not counted; the new length is loaded instead.
- Reset mid-transfer → IDLE on the next clock edge. No FIFO write and no done/error pulse are produced.

## Configuration
- `DDR_RX_SEQ_WATCHDOG_EN` defined:
  - A cycle counter runs in every active state and clears on each `i_rx_mode_done` and on each state entry.
  - When it reaches `WD_CYCLES` → ERROR with code 4.
- Undefined: no watchdog; the sequencer waits indefinitely and code 4 is never produced.

## Test plan
- Start, preamble `i_rx_pre`=1, bytes 0xAD and 0xCA, parity OK, then preamble `i_rx_pre`=0, token OK, CRC OK → FIFO writes 0xAD then 0xCA; `o_word_count`=1; `o_done` pulses once; `o_error_code`=0.
- Three data words, then a CRC word → 6 FIFO writes in order, `o_word_count`=3, `o_done`=1.
- `i_rx_error`=1 at PARITY done → no word increment; `o_error` pulse; `o_error_code`=1; IDLE next cycle.
- `i_fifo_full`=1 at BYTE2 done → exactly one write (BYTE1 only); `o_error_code`=2.
- `MAX_WORDS`=2 and the target sends a third data preamble → `o_error_code`=3, no further writes.
- Abort asserted during BYTE1 together with `i_rx_mode_done` → no FIFO write, `o_error_code`=5.
- With `DDR_RX_SEQ_WATCHDOG_EN` and `WD_CYCLES`=64, no done after start → `o_error` at cycle 64 after PREAMBLE entry, `o_error_code`=4.
